// File: rtl/fft_frame_loader.sv
// fft_frame_loader: ping-pong loader that packs serial (a,b) sample pairs into parallel frames
module fft_frame_loader #(
  parameter int SAMPLE_W  = 4,
  parameter int FRAME_LEN = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [SAMPLE_W-1:0]             in_a,
  input  logic [SAMPLE_W-1:0]             in_b,
  input  logic                            flush,
  output logic                            frame_valid,
  input  logic                            frame_ready,
  output logic [FRAME_LEN*SAMPLE_W-1:0]   frame_a,
  output logic [FRAME_LEN*SAMPLE_W-1:0]   frame_b,
  output logic [$clog2(FRAME_LEN)-1:0]    fill_idx,
  output logic [1:0]                      frames_pending,
  output logic                            overflow
);
  localparam int IW = $clog2(FRAME_LEN);
  localparam int FW = FRAME_LEN * SAMPLE_W;
  logic [1:0]    bank_full_q, bank_full_d;
  logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic          overflow_q, overflow_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [FW-1:0] a_q [2];
  logic [FW-1:0] b_q [2];
  logic          accept, last, consume;
  assign in_ready       = !bank_full_q[wr_bank_q] && !flush;
  assign frame_valid    = bank_full_q[rd_bank_q];
  assign frame_a        = a_q[rd_bank_q];
  assign frame_b        = b_q[rd_bank_q];
  assign fill_idx       = wr_idx_q;
  assign frames_pending = {1'b0, bank_full_q[0]} + {1'b0, bank_full_q[1]};
  assign overflow       = overflow_q;
  assign accept         = in_valid && in_ready;
  assign last           = accept && (wr_idx_q == IW'(FRAME_LEN - 1));
  assign consume        = frame_valid && frame_ready;
  always_comb begin
    bank_full_d = bank_full_q;
    if (last) bank_full_d[wr_bank_q] = 1'b1;
    if (consume) bank_full_d[rd_bank_q] = 1'b0;
    wr_bank_d  = wr_bank_q ^ last;
    rd_bank_d  = rd_bank_q ^ consume;
    wr_idx_d   = flush ? '0 : accept ? wr_idx_q + IW'(1) : wr_idx_q;
    overflow_d = overflow_q || (in_valid && !in_ready && !flush);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full_q <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      overflow_q  <= 1'b0;
      a_q         <= '{default: '0};
      b_q         <= '{default: '0};
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_idx_q    <= wr_idx_d;
      overflow_q  <= overflow_d;
      if (accept) begin
        a_q[wr_bank_q][wr_idx_q*SAMPLE_W +: SAMPLE_W] <= in_a;
        b_q[wr_bank_q][wr_idx_q*SAMPLE_W +: SAMPLE_W] <= in_b;
      end
    end
  end
endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader: scoreboard bench for fft_frame_loader
module tb_fft_frame_loader;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, frame_valid, frame_ready, overflow;
  logic [3:0]  in_a, in_b;
  logic [31:0] frame_a, frame_b;
  logic [2:0]  fill_idx;
  logic [1:0]  frames_pending;
  int          n_cmp = 0;
  int          n_err = 0;
  int          mp, cnt;
  bit          mov;
  logic [31:0] ca, cb;
  logic [63:0] sbq [$];
  always #5 clk = ~clk;
  fft_frame_loader #(.SAMPLE_W(4), .FRAME_LEN(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .flush(flush), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_a(frame_a), .frame_b(frame_b),
    .fill_idx(fill_idx), .frames_pending(frames_pending), .overflow(overflow)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; frame_ready = 1'b0; in_a = '0; in_b = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    mp = 0; cnt = 0; mov = 1'b0; ca = '0; cb = '0;
    sbq.delete();
  endtask
  task automatic cyc(input bit v, input logic [3:0] a, input logic [3:0] b, input bit fl, input bit fr);
    bit exp_rdy, cons, done;
    in_valid = v; in_a = a; in_b = b; flush = fl; frame_ready = fr;
    #1;
    exp_rdy = (mp < 2) && !fl;
    chk("in_ready", in_ready, exp_rdy);
    chk("frame_valid", frame_valid, mp > 0);
    chk("frames_pending", frames_pending, mp);
    chk("fill_idx", fill_idx, cnt);
    chk("overflow", overflow, mov);
    cons = (mp > 0) && fr;
    done = 1'b0;
    if (mp > 0) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL scoreboard: frame pending but no expected frame queued");
      end else begin
        chk("frame_a", frame_a, sbq[0][63:32]);
        chk("frame_b", frame_b, sbq[0][31:0]);
      end
    end
    if (v && !exp_rdy && !fl) mov = 1'b1;
    if (fl) cnt = 0;
    if (v && exp_rdy) begin
      ca[cnt*4 +: 4] = a;
      cb[cnt*4 +: 4] = b;
      cnt++;
      if (cnt == 8) begin
        sbq.push_back({ca, cb});
        cnt = 0;
        done = 1'b1;
      end
    end
    if (cons && sbq.size() > 0) void'(sbq.pop_front());
    mp = mp + int'(done) - int'(cons);
    @(posedge clk); #1;
  endtask
  initial begin
    do_reset();
    chk("rst_frame_a", frame_a, 32'h0);
    chk("rst_frame_b", frame_b, 32'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    // basic frame
    for (int k = 0; k < 8; k++) cyc(1'b1, 4'(k + 1), 4'(2 * k), 1'b0, 1'b1);
    chk("basic_fv", frame_valid, 1'b1);
    chk("basic_a", frame_a, 32'h87654321);
    chk("basic_b", frame_b, 32'hECA86420);
    cyc(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("basic_drop", frame_valid, 1'b0);
    // back-pressure and overflow
    do_reset();
    for (int k = 0; k < 16; k++) cyc(1'b1, 4'($urandom), 4'($urandom), 1'b0, 1'b0);
    chk("bp_pending", frames_pending, 2'd2);
    chk("bp_in_ready", in_ready, 1'b0);
    cyc(1'b1, 4'h5, 4'hA, 1'b0, 1'b0);
    chk("bp_overflow", overflow, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("bp_in_ready_after", in_ready, 1'b1);
    cyc(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("bp_drained", frames_pending, 2'd0);
    // simultaneous completion and consume
    do_reset();
    for (int k = 0; k < 15; k++) cyc(1'b1, 4'($urandom), 4'($urandom), 1'b0, 1'b0);
    cyc(1'b1, 4'h9, 4'h3, 1'b0, 1'b1);
    chk("simul_pending", frames_pending, 2'd1);
    cyc(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    // flush
    do_reset();
    for (int k = 0; k < 5; k++) cyc(1'b1, 4'hF, 4'hF, 1'b0, 1'b1);
    cyc(1'b1, 4'hE, 4'hE, 1'b1, 1'b1);
    chk("flush_idx", fill_idx, 3'd0);
    chk("flush_ovf", overflow, 1'b0);
    for (int k = 0; k < 8; k++) cyc(1'b1, 4'(k), 4'(15 - k), 1'b0, 1'b0);
    chk("flush_a", frame_a, 32'h76543210);
    chk("flush_b", frame_b, 32'h89ABCDEF);
    cyc(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    // reset mid-operation
    do_reset();
    for (int k = 0; k < 11; k++) cyc(1'b1, 4'($urandom), 4'($urandom), 1'b0, 1'b0);
    do_reset();
    chk("mid_fv", frame_valid, 1'b0);
    chk("mid_pending", frames_pending, 2'd0);
    chk("mid_idx", fill_idx, 3'd0);
    chk("mid_ovf", overflow, 1'b0);
    chk("mid_ready", in_ready, 1'b1);
    // full-rate random stream
    for (int k = 0; k < 64; k++) cyc(1'b1, 4'($urandom), 4'($urandom), 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("stream_drained", sbq.size(), 0);
    chk("stream_ovf", overflow, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
